// File: rtl/force_release_ctrl_if.sv
// Command port for force_release_ctrl: valid/ready handshake carrying op, index and force value.
// The master holds valid and payload stable until cmd_ready is seen at a rising edge.
interface force_release_ctrl_if #(
    parameter int N      = 8,
    parameter int ELEM_W = 1,
    parameter int IDX_W  = (N > 1) ? $clog2(N) : 1
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [IDX_W-1:0]  cmd_idx;
    logic [ELEM_W-1:0] cmd_val;

    modport master (output cmd_valid, cmd_op, cmd_idx, cmd_val, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_idx, cmd_val, output cmd_ready);
endinterface

// File: rtl/force_release_ctrl.sv
// Per-element force/release state with resolved net output; 1-cycle command latency, net follows drv combinationally.
// cmd_ready is low for the N cycles of a RELEASE_ALL sweep, otherwise a command is taken every cycle.
module force_release_ctrl #(
    parameter int N      = 8,
    parameter int ELEM_W = 1,
    parameter int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    force_release_ctrl_if.slave cmd,
    input  logic [N*ELEM_W-1:0] drv,
    output logic [N*ELEM_W-1:0] net,
    output logic [N-1:0]        force_o,
    output logic [N-1:0]        release_pulse,
    output logic                busy,
    output logic                err
);
    typedef enum logic {IDLE, SWEEP} state_t;

    localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(N);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  cnt, cnt_nxt;
    logic [N-1:0]      forced, forced_nxt, pulse_nxt;
    logic [ELEM_W-1:0] fval [N];
    logic [ELEM_W-1:0] fval_nxt [N];
    logic              err_nxt;
    logic              accept;
    logic              idx_ok;

    assign cmd.cmd_ready = (state == IDLE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign idx_ok        = ({1'b0, cmd.cmd_idx} < N_EXT);
    assign busy          = (state == SWEEP);
    assign force_o       = forced;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        forced_nxt = forced;
        fval_nxt   = fval;
        pulse_nxt  = '0;
        err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        2'b01: begin
                            if (idx_ok) begin
                                forced_nxt[cmd.cmd_idx] = 1'b1;
                                fval_nxt[cmd.cmd_idx]   = cmd.cmd_val;
                            end else begin
                                err_nxt = 1'b1;
                            end
                        end
                        2'b10: begin
                            if (!idx_ok) begin
                                err_nxt = 1'b1;
                            end else if (forced[cmd.cmd_idx]) begin
                                forced_nxt[cmd.cmd_idx] = 1'b0;
                                pulse_nxt[cmd.cmd_idx]  = 1'b1;
                            end
                        end
                        2'b11: begin
                            state_nxt = SWEEP;
                            cnt_nxt   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            SWEEP: begin
                // One element per cycle; the pulse rule matches a single RELEASE.
                if (forced[cnt]) begin
                    forced_nxt[cnt] = 1'b0;
                    pulse_nxt[cnt]  = 1'b1;
                end
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + IDX_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            forced        <= '0;
            release_pulse <= '0;
            err           <= 1'b0;
            for (int i = 0; i < N; i++) fval[i] <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            forced        <= forced_nxt;
            fval          <= fval_nxt;
            release_pulse <= pulse_nxt;
            err           <= err_nxt;
        end
    end

    always_comb begin
        net = drv;
        for (int i = 0; i < N; i++) begin
            if (forced[i]) net[i*ELEM_W +: ELEM_W] = fval[i];
        end
    end
endmodule

// File: tb/tb_force_release_ctrl.sv
// Directed bench: an N=8 instance for the main behaviour and an N=6 instance for out-of-range indices.
module tb_force_release_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    force_release_ctrl_if #(.N(8), .ELEM_W(1), .IDX_W(3)) a_if ();
    force_release_ctrl_if #(.N(6), .ELEM_W(1), .IDX_W(3)) b_if ();

    logic [7:0] a_drv, a_net, a_force, a_pulse;
    logic       a_busy, a_err;
    logic [5:0] b_drv, b_net, b_force, b_pulse;
    logic       b_busy, b_err;

    force_release_ctrl #(.N(8), .ELEM_W(1), .IDX_W(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd(a_if), .drv(a_drv), .net(a_net),
        .force_o(a_force), .release_pulse(a_pulse), .busy(a_busy), .err(a_err)
    );
    force_release_ctrl #(.N(6), .ELEM_W(1), .IDX_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd(b_if), .drv(b_drv), .net(b_net),
        .force_o(b_force), .release_pulse(b_pulse), .busy(b_busy), .err(b_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd_a(input logic [1:0] op, input logic [2:0] idx, input logic val);
        a_if.cmd_valid = 1'b1;
        a_if.cmd_op    = op;
        a_if.cmd_idx   = idx;
        a_if.cmd_val   = val;
        tick();
        a_if.cmd_valid = 1'b0;
        a_if.cmd_op    = 2'b00;
    endtask

    task automatic cmd_b(input logic [1:0] op, input logic [2:0] idx, input logic val);
        b_if.cmd_valid = 1'b1;
        b_if.cmd_op    = op;
        b_if.cmd_idx   = idx;
        b_if.cmd_val   = val;
        tick();
        b_if.cmd_valid = 1'b0;
        b_if.cmd_op    = 2'b00;
    endtask

    initial begin
        logic [7:0] exp_force;
        logic [7:0] exp_pulse;

        a_if.cmd_valid = 1'b0; a_if.cmd_op = 2'b00; a_if.cmd_idx = '0; a_if.cmd_val = 1'b0;
        b_if.cmd_valid = 1'b0; b_if.cmd_op = 2'b00; b_if.cmd_idx = '0; b_if.cmd_val = 1'b0;
        a_drv = 8'hA5;
        b_drv = 6'h00;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_net", a_net, 8'hA5);
        chk("rst_force", a_force, 8'h00);
        chk("rst_ready", a_if.cmd_ready, 1'b1);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_pulse", a_pulse, 8'h00);
        chk("rst_err", a_err, 1'b0);

        cmd_a(2'b00, 3'd3, 1'b1);
        chk("nop_net", a_net, 8'hA5);
        chk("nop_force", a_force, 8'h00);

        // Force / release
        a_drv = 8'hFF;
        cmd_a(2'b01, 3'd3, 1'b0);
        chk("force_net", a_net, 8'hF7);
        chk("force_force", a_force, 8'h08);
        a_drv = 8'hF7;
        #1;
        chk("force_drv_toggle0", a_net, 8'hF7);
        a_drv = 8'hFF;
        #1;
        chk("force_drv_toggle1", a_net, 8'hF7);
        cmd_a(2'b10, 3'd3, 1'b0);
        chk("rel_pulse", a_pulse, 8'h08);
        chk("rel_force", a_force, 8'h00);
        chk("rel_net", a_net, 8'hFF);
        tick();
        chk("rel_pulse_drop", a_pulse, 8'h00);
        cmd_a(2'b10, 3'd3, 1'b0);
        chk("rel_again_pulse", a_pulse, 8'h00);
        chk("rel_again_err", a_err, 1'b0);

        // Overwrite on consecutive cycles
        a_drv = 8'h00;
        cmd_a(2'b01, 3'd2, 1'b1);
        chk("ovw1_net", a_net, 8'h04);
        chk("ovw1_force", a_force, 8'h04);
        cmd_a(2'b01, 3'd2, 1'b0);
        chk("ovw2_net", a_net, 8'h00);
        chk("ovw2_force", a_force, 8'h04);
        chk("ovw2_pulse", a_pulse, 8'h00);
        cmd_a(2'b10, 3'd2, 1'b0);
        chk("ovw_rel_pulse", a_pulse, 8'h04);

        // RELEASE_ALL sweep with a command held across it
        cmd_a(2'b01, 3'd0, 1'b1);
        cmd_a(2'b01, 3'd5, 1'b1);
        cmd_a(2'b01, 3'd7, 1'b1);
        chk("sw_setup_force", a_force, 8'hA1);
        chk("sw_setup_net", a_net, 8'hA1);
        cmd_a(2'b11, 3'd0, 1'b0);
        chk("sw_start_busy", a_busy, 1'b1);
        chk("sw_start_ready", a_if.cmd_ready, 1'b0);
        chk("sw_start_pulse", a_pulse, 8'h00);
        a_if.cmd_valid = 1'b1;
        a_if.cmd_op    = 2'b01;
        a_if.cmd_idx   = 3'd4;
        a_if.cmd_val   = 1'b1;
        exp_force = 8'hA1;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_pulse = exp_force & (8'h01 << k);
            exp_force = exp_force & ~(8'h01 << k);
            chk($sformatf("sw_pulse_%0d", k), a_pulse, exp_pulse);
            chk($sformatf("sw_force_%0d", k), a_force, exp_force);
            chk($sformatf("sw_busy_%0d", k), a_busy, (k < 7) ? 1'b1 : 1'b0);
            chk($sformatf("sw_ready_%0d", k), a_if.cmd_ready, (k == 7) ? 1'b1 : 1'b0);
        end
        chk("sw_end_net", a_net, 8'h00);
        tick();
        a_if.cmd_valid = 1'b0;
        a_if.cmd_op    = 2'b00;
        chk("sw_held_force", a_force, 8'h10);
        chk("sw_held_net", a_net, 8'h10);
        chk("sw_held_pulse", a_pulse, 8'h00);

        // Reset in the middle of a sweep
        a_drv = 8'h3C;
        for (int i = 0; i < 8; i++) cmd_a(2'b01, 3'(i), 1'b1);
        chk("mrst_setup_force", a_force, 8'hFF);
        chk("mrst_setup_net", a_net, 8'hFF);
        cmd_a(2'b11, 3'd0, 1'b0);
        tick();
        chk("mrst_c1_pulse", a_pulse, 8'h01);
        tick();
        chk("mrst_c2_pulse", a_pulse, 8'h02);
        rst_n = 1'b0;
        #2;
        chk("mrst_force", a_force, 8'h00);
        chk("mrst_busy", a_busy, 1'b0);
        chk("mrst_pulse", a_pulse, 8'h00);
        chk("mrst_net", a_net, 8'h3C);
        chk("mrst_ready", a_if.cmd_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mrst_after_pulse", a_pulse, 8'h00);
        chk("mrst_after_busy", a_busy, 1'b0);

        // Out-of-range index on the N=6 instance
        cmd_b(2'b01, 3'd2, 1'b1);
        chk("b_force_ok", b_force, 6'h04);
        chk("b_ok_err", b_err, 1'b0);
        cmd_b(2'b01, 3'd6, 1'b1);
        chk("b_oor_err", b_err, 1'b1);
        chk("b_oor_force", b_force, 6'h04);
        tick();
        chk("b_oor_err_drop", b_err, 1'b0);
        cmd_b(2'b10, 3'd7, 1'b0);
        chk("b_oor_rel_err", b_err, 1'b1);
        chk("b_oor_rel_force", b_force, 6'h04);
        chk("b_oor_rel_pulse", b_pulse, 6'h00);
        chk("b_net", b_net, 6'h04);
        chk("b_busy", b_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/force_release_ctrl.md
# force_release_ctrl

Force/release controller for an array of `N` signal-value elements; it owns the other end of the per-element force/force_value/release interface. It accepts force and release commands over a valid/ready port and holds the per-element force state. It drives the per-element `force_o` enables and one-cycle release notifications, and outputs the resolved net value: the forced value where an element is forced, otherwise the driver value.

## Interface
- `N`, default 8: number of array elements.
- `ELEM_W`, default 1: bits per element.
- `IDX_W`, default `max(1, clog2(N))`: width of the element index.
- `clk`, in, 1: the single clock; every register is rising-edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `cmd_valid`, in, 1: a command is presented.
- `cmd_ready`, out, 1: the block can accept a command.
- `cmd_op`, in, 2: 00 NOP, 01 FORCE, 10 RELEASE, 11 RELEASE_ALL.
- `cmd_idx`, in, IDX_W: target element for FORCE and RELEASE.
- `cmd_val`, in, ELEM_W: force value for FORCE.
- `drv`, in, N*ELEM_W: normal driver value; element i is `drv[i*ELEM_W +: ELEM_W]`.
- `net`, out, N*ELEM_W: resolved value per element.
- `force_o`, out, N: bit i high while element i is forced.
- `release_pulse`, out, N: one-cycle pulse when element i leaves the forced state.
- `busy`, out, 1: a RELEASE_ALL sweep is in progress.
- `err`, out, 1: one-cycle pulse on an out-of-range index.

## Operation
- A command is accepted on a rising edge where `cmd_valid & cmd_ready`. `cmd_ready = (state == IDLE)`.
- State machine states: IDLE and SWEEP. The per-element registers are `forced[N]` and `fval[N]` (ELEM_W bits each).
- **NOP**: accepted with no effect.
- **FORCE idx, val**
  - Sets `forced[idx] = 1` and `fval[idx] = val`.
  - Re-forcing an element that is already forced overwrites `fval` and produces no pulse.
- **RELEASE idx**
  - If the element is forced: clears `forced[idx]` and sets `release_pulse[idx] = 1` for one cycle.
  - If the element is not forced: no effect and no pulse.
  - `fval[idx]` is retained but unused.
- **Out-of-range index** (`cmd_idx >= N` for FORCE or RELEASE): no state change; `err` = 1 for one cycle.
- **RELEASE_ALL**
  - IDLE -> SWEEP; a sweep counter starts at 0.
  - Each SWEEP cycle performs RELEASE on element `cnt`, with the same pulse rule, then increments `cnt`.
  - After `cnt == N-1` is processed, SWEEP -> IDLE.
  - `busy = (state == SWEEP)`.
- **Resolution** (combinational from registers and `drv`): `net[i] = forced[i] ? fval[i] : drv[i]`.
- **Reset values**
  - `forced`, `fval`, `release_pulse`, `err` and `busy` are all 0; `cmd_ready` = 1; state = IDLE; counter = 0.
  - `net` therefore equals `drv` immediately after reset.
- **Reset mid-sweep**: the block returns to IDLE and clears all forces. No release pulses are emitted for the cleared elements.
- Commands presented during SWEEP are not accepted; `cmd_ready` is 0, and the initiator must hold `cmd_valid` and its payload stable until acceptance.

## Timing
- **FORCE**: accepted at edge T; `force_o[idx]` and `net[idx] = val` are visible after edge T, i.e. 1-cycle latency.
- **RELEASE**: accepted at edge T; after edge T, `force_o[idx] = 0`, `release_pulse[idx] = 1` and `net[idx]` follows `drv`. The pulse drops after edge T+1.
- **RELEASE_ALL**
  - Accepted at edge T.
  - Element k is released at edge T+1+k, with its pulse high for the cycle after that edge.
  - `busy` is high from after edge T until after edge T+N.
  - `cmd_ready` returns high after edge T+N, which is N cycles of unavailability.
- **`err`**: high during the cycle after the offending acceptance edge.
- **`drv` changes**: propagate to `net` combinationally (zero latency) for unforced elements. `drv` changes never alter forced elements.
- **Back-to-back**: FORCE or RELEASE commands can be accepted on consecutive cycles. FORCE then RELEASE of the same index on consecutive edges yields one cycle of forced value, then the pulse.

## Test plan
- **Reset / NOP**: after reset, `drv = 0xA5` (N=8, ELEM_W=1) -> `net = 0xA5`, `force_o = 0`, `cmd_ready = 1`. A NOP changes nothing.
- **Force / release**: FORCE idx 3 val 0, with `drv = 0xFF` -> next cycle `net = 0xF7`, `force_o = 0x08`. Toggling `drv[3]` leaves `net[3]` at 0. RELEASE idx 3 -> `release_pulse = 0x08` for one cycle, then `net = 0xFF`. A second RELEASE idx 3 -> no pulse.
- **RELEASE_ALL sweep**
  - Setup: FORCE idx 0, 5 and 7 (val 1), with `drv = 0`, then RELEASE_ALL.
  - `busy` and `!cmd_ready` last 8 cycles.
  - Pulses on bits 0, 5 and 7 occur at sweep cycles 1, 6 and 8 only.
  - Final `net = 0`.
  - A command held valid during the sweep is accepted on the first cycle `cmd_ready` = 1.
- **Error**: with N=6 and IDX_W=3, FORCE idx 6 -> `err` pulse for one cycle and no change to `force_o`.
- **Reset mid-sweep**: assert `rst_n` = 0 during cycle 3 of a sweep over 8 forced elements -> `force_o = 0`, `busy = 0`, no pulses, `net = drv`.
- **Overwrite**: FORCE idx 2 val 1 then FORCE idx 2 val 0 on consecutive cycles -> `net[2]` is 1 then 0, `force_o[2]` stays 1 throughout, and no release pulse occurs.
